des_key_sched_seq: RTL and testbench
====================================

Name: des_key_sched_seq

Overview:
Sequential, parametrised successor to the combinational DES key scheduler. Latches a 64-bit key on a start pulse and produces one 48-bit round subkey per accepted handshake. Keys come in encrypt order (K1..Kn) or decrypt order (Kn..K1). Round count and shift schedule are parameters, and byte parity is checked optionally. Sits between the key-load interface and an iterative (one-round-per-cycle) DES datapath, replacing the 768-bit parallel subkey bus.

Parameters:
ROUNDS, 16, number of subkeys generated (1..16)
SHIFT_MAP, 16'h7EFC, bit r-1 = 1 means round r rotates by 2, 0 means by 1 (default = standard DES 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1)
PARITY_CHECK, 1, 1 = check odd parity per key byte; 0 = parity_err tied 0
RW, 5, width of subkey_round (must hold ROUNDS)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  load request; accepted only when busy=0
decrypt  in  1  sampled with start; 1 = reverse subkey order
key_in  in  64  key, [64:1], bit 64 = DES bit 1 (MSB), parity bits at 57,49,..,1
subkey  out  48  current round key, [48:1], bit 48 = DES bit 1
subkey_round  out  RW  1-based index of subkey in output order (1..ROUNDS)
subkey_valid  out  1  subkey/subkey_round valid
subkey_ready  in  1  consumer accepts subkey when valid&ready
busy  out  1  high from accept of start to final handshake inclusive
done  out  1  one-cycle pulse the cycle after final handshake
parity_err  out  1  sticky per key: set if any key_in byte has even parity

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; subkey=0, subkey_round=0, subkey_valid=0, busy=0, done=0, parity_err=0; C/D registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge T → PC1(key_in) split into C0 (PC1[56:29]) and D0 (PC1[28:1]). Encrypt: C/D loaded with rot-left(C0/D0, shift[1]). Decrypt: C/D loaded with C0/D0 unchanged (requires total shift = 28). decrypt latched; parity_err computed from key_in; go to RUN. busy=1 and subkey_valid=1 from T+1; subkey_round=1.
- subkey = PC2({C,D}) registered, valid at T+1 (1-cycle latency from start).
- RUN: on valid&ready with subkey_round<ROUNDS, next subkey is valid the following cycle, so there is zero bubble at full throughput.
  - Encrypt: C/D rotate left by shift[subkey_round+1].
  - Decrypt: C/D rotate right by shift[ROUNDS+1-subkey_round].
  - subkey_round increments.
- valid&!ready: subkey, subkey_round, C/D held stable; valid stays high.
- Handshake with subkey_round=ROUNDS → subkey_valid=0, busy=0, FSM=DONE; done=1 for exactly that next cycle, then IDLE.
- start while busy=1 or in DONE: ignored (no reload, no abort).
- start in the same cycle done=1 is not accepted; the earliest accept is the following cycle.
- Rotation: 28-bit circular within C and D independently; shift amount is 1 or 2 only.
- Parity: parity_err stays set until the next accepted start. It does not block key generation.
- Reset mid-operation: all outputs return to reset values immediately; no done pulse.
- Constraint: for decrypt correctness the sum of shifts over rounds 1..ROUNDS ≡ 0 mod 28. ROUNDS/SHIFT_MAP values violating this make decrypt output undefined. Encrypt output stays correct.
- PC1 and PC2 are the standard DES tables, indexed MSB-first as on key_in/subkey.

Test Plan:
- Encrypt, ready=1, key_in=64'h133457799BBCDFF1, start at T → subkey=48'h1B02EFFC7072, round=1 at T+1; round 16 at T+16 = 48'hCB3D8B0E17F5; done=1 at T+17; parity_err=0.
- Decrypt, same key, ready=1 → round 1 = 48'hCB3D8B0E17F5, round 16 = 48'h1B02EFFC7072; all 16 equal the encrypt sequence reversed.
- Backpressure: ready toggled pseudo-randomly → sequence identical to the ready=1 case; subkey and round stable across every stalled cycle; busy stays high throughout.
- key_in=64'h133457799BBCDFF0 (last byte even) → parity_err=1 from T+1, subkeys unchanged. Next start with 64'h133457799BBCDFF1 → parity_err=0.
- start pulsed at round 5 with a different key → ignored, sequence completes for the original key. rst_n=0 at round 8 → valid=0, busy=0, done never pulses; restart works.
- ROUNDS=8, SHIFT_MAP=16'h00FC, encrypt → 8 subkeys equal to standard K1..K8, done after the 8th handshake.

Source files
------------

// File: rtl/des_key_sched_seq.sv
// Sequential DES key scheduler. It latches a key on start and emits one
// PC2 subkey per valid/ready handshake, in encrypt or decrypt order.
module des_key_sched_seq #(
  parameter int unsigned ROUNDS       = 16,
  parameter logic [15:0] SHIFT_MAP    = 16'h7EFC,
  parameter bit          PARITY_CHECK = 1'b1,
  parameter int unsigned RW           = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          decrypt,
  input  logic [63:0]   key_in,
  output logic [47:0]   subkey,
  output logic [RW-1:0] subkey_round,
  output logic          subkey_valid,
  input  logic          subkey_ready,
  output logic          busy,
  output logic          done,
  output logic          parity_err
);

  localparam int unsigned KW  = 64;
  localparam int unsigned PW  = 56;
  localparam int unsigned CW  = 28;
  localparam int unsigned SKW = 48;
  localparam logic [31:0] MAP_EXT = 32'(SHIFT_MAP);

  // DES permuted-choice tables, 1-based source bit numbers, MSB first
  localparam int unsigned PC1_TAB [PW] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_TAB [SKW] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [PW-1:0] pc1(input logic [KW-1:0] k);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(PW); i++)
      p[6'(PW - 1 - i)] = k[6'(KW - PC1_TAB[i])];
    return p;
  endfunction

  function automatic logic [SKW-1:0] pc2(input logic [PW-1:0] cd);
    logic [SKW-1:0] s;
    s = '0;
    for (int i = 0; i < int'(SKW); i++)
      s[6'(SKW - 1 - i)] = cd[6'(PW - PC2_TAB[i])];
    return s;
  endfunction

  function automatic logic [CW-1:0] rotl(input logic [CW-1:0] x, input logic two);
    return two ? {x[CW-3:0], x[CW-1:CW-2]} : {x[CW-2:0], x[CW-1]};
  endfunction

  function automatic logic [CW-1:0] rotr(input logic [CW-1:0] x, input logic two);
    return two ? {x[1:0], x[CW-1:2]} : {x[0], x[CW-1:1]};
  endfunction

  // Odd parity expected on every key byte
  function automatic logic key_par_err(input logic [KW-1:0] k);
    logic err;
    err = 1'b0;
    for (int b = 0; b < 8; b++)
      err = err | ~(^k[8*b +: 8]);
    return err;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   c_q, c_d, d_q, d_d;
  logic            dec_q, dec_d;
  logic [RW-1:0]   round_q, round_d;
  logic [SKW-1:0]  subkey_q, subkey_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;

  logic [PW-1:0]   pc_c;
  logic            par_err_c;
  logic            enc_two, dec_two;

  assign pc_c      = pc1(key_in);
  assign par_err_c = key_par_err(key_in);
  // Shift for the next round: encrypt walks forward, decrypt undoes backwards
  assign enc_two   = MAP_EXT[5'(round_q)];
  assign dec_two   = MAP_EXT[5'(RW'(ROUNDS) - round_q)];

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    dec_d    = dec_q;
    round_d  = round_q;
    subkey_d = subkey_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    perr_d   = perr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Decrypt starts from C0/D0, which equals C16/D16 after a full 28-bit rotation
          if (decrypt) begin
            c_d = pc_c[PW-1:CW];
            d_d = pc_c[CW-1:0];
          end else begin
            c_d = rotl(pc_c[PW-1:CW], SHIFT_MAP[0]);
            d_d = rotl(pc_c[CW-1:0], SHIFT_MAP[0]);
          end
          dec_d    = decrypt;
          round_d  = RW'(1);
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          perr_d   = PARITY_CHECK & par_err_c;
          subkey_d = pc2({c_d, d_d});
          state_d  = RUN;
        end
      end
      RUN: begin
        if (valid_q && subkey_ready) begin
          if (round_q == RW'(ROUNDS)) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            if (dec_q) begin
              c_d = rotr(c_q, dec_two);
              d_d = rotr(d_q, dec_two);
            end else begin
              c_d = rotl(c_q, enc_two);
              d_d = rotl(d_q, enc_two);
            end
            round_d  = round_q + RW'(1);
            subkey_d = pc2({c_d, d_d});
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      dec_q    <= 1'b0;
      round_q  <= '0;
      subkey_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      dec_q    <= dec_d;
      round_q  <= round_d;
      subkey_q <= subkey_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
    end
  end

  assign subkey       = subkey_q;
  assign subkey_round = round_q;
  assign subkey_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Bench for des_key_sched_seq: a transaction-level reference model checked every
// cycle, plus literal subkeys from the classic 133457799BBCDFF1 example.
module tb_des_key_sched_seq;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int          R_OF   [2] = '{16, 8};
  localparam logic [15:0] MAP_OF [2] = '{16'h7EFC, 16'h00FC};

  localparam logic [63:0] KEY_OK  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, decrypt = 1'b0, ready = 1'b1;
  logic [63:0] key_in = '0;
  logic [47:0] subkey;
  logic [4:0]  subkey_round;
  logic        subkey_valid, busy, done, parity_err;
  logic start8 = 1'b0, decrypt8 = 1'b0, ready8 = 1'b1;
  logic [63:0] key8 = '0;
  logic [47:0] subkey8;
  logic [4:0]  subkey_round8;
  logic        subkey_valid8, busy8, done8, parity_err8;

  int checks = 0, errors = 0;
  bit rnd_ready = 1'b0;

  // Reference model state per unit (0 = 16-round DUT, 1 = 8-round DUT)
  bit          m_act [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  bit          m_dec [2] = '{0, 0};
  bit          m_perr [2] = '{0, 0};
  int          m_k [2] = '{0, 0};
  logic [63:0] m_key [2] = '{64'h0, 64'h0};

  always #5 clk = ~clk;

  des_key_sched_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_in),
    .subkey(subkey), .subkey_round(subkey_round), .subkey_valid(subkey_valid),
    .subkey_ready(ready), .busy(busy), .done(done), .parity_err(parity_err));

  des_key_sched_seq #(.ROUNDS(8), .SHIFT_MAP(16'h00FC)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .decrypt(decrypt8), .key_in(key8),
    .subkey(subkey8), .subkey_round(subkey_round8), .subkey_valid(subkey_valid8),
    .subkey_ready(ready8), .busy(busy8), .done(done8), .parity_err(parity_err8));

  // Textbook DES: Ki = PC2(rotl(C0, s_i), rotl(D0, s_i)), s_i = cumulative shift
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int i,
                                             input logic [15:0] map);
    logic [27:0] c, d;
    logic [55:0] cc, dd, cd;
    logic [47:0] k;
    int s;
    s = 0;
    for (int r = 1; r <= i; r++) s = (s + (map[4'(r - 1)] ? 2 : 1)) % 28;
    for (int j = 0; j < 28; j++) begin
      c[5'(27 - j)] = key[6'(64 - PC1[j])];
      d[5'(27 - j)] = key[6'(64 - PC1[j + 28])];
    end
    cc = {c, c} << s;
    dd = {d, d} << s;
    cd = {cc[55:28], dd[55:28]};
    for (int j = 0; j < 48; j++) k[6'(47 - j)] = cd[6'(56 - PC2[j])];
    return k;
  endfunction

  function automatic bit ref_par_err(input logic [63:0] k);
    for (int b = 0; b < 8; b++)
      if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int u, input logic st, input logic dc,
                            input logic [63:0] k, input logic rd);
    bit nd;
    nd = 1'b0;
    if (!m_act[u] && !m_done[u] && st) begin
      m_act[u] = 1'b1; m_k[u] = 0; m_dec[u] = dc; m_key[u] = k;
      m_perr[u] = ref_par_err(k);
    end else if (m_act[u] && rd) begin
      if (m_k[u] == R_OF[u] - 1) begin
        m_act[u] = 1'b0; nd = 1'b1;
      end else m_k[u]++;
    end
    m_done[u] = nd;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_act[u] = 1'b0; m_done[u] = 1'b0; m_dec[u] = 1'b0; m_perr[u] = 1'b0; m_k[u] = 0;
      end
    end else begin
      model_step(0, start, decrypt, key_in, ready);
      model_step(1, start8, decrypt8, key8, ready8);
    end
  end

  task automatic chk_unit(input int u, input logic [47:0] sk, input logic [4:0] rnd,
                          input logic v, input logic b, input logic dn, input logic pe);
    int idx;
    chk($sformatf("u%0d valid", u), 64'(v), 64'(m_act[u]));
    chk($sformatf("u%0d busy", u), 64'(b), 64'(m_act[u]));
    chk($sformatf("u%0d done", u), 64'(dn), 64'(m_done[u]));
    chk($sformatf("u%0d parity_err", u), 64'(pe), 64'(m_perr[u]));
    if (m_act[u]) begin
      idx = m_dec[u] ? R_OF[u] - m_k[u] : m_k[u] + 1;
      chk($sformatf("u%0d round", u), 64'(rnd), 64'(m_k[u] + 1));
      chk($sformatf("u%0d subkey", u), 64'(sk), 64'(ref_subkey(m_key[u], idx, MAP_OF[u])));
    end
  endtask

  always @(negedge clk) begin
    chk_unit(0, subkey, subkey_round, subkey_valid, busy, done, parity_err);
    chk_unit(1, subkey8, subkey_round8, subkey_valid8, busy8, done8, parity_err8);
  end

  initial forever begin
    @(posedge clk); #1;
    ready  = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
    ready8 = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go(input logic [63:0] k, input logic dec);
    start = 1'b1; key_in = k; decrypt = dec;
    tick(1);
    start = 1'b0;
  endtask

  task automatic go8(input logic [63:0] k);
    start8 = 1'b1; key8 = k;
    tick(1);
    start8 = 1'b0;
  endtask

  task automatic wait_done(input int u, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      seen = (u == 0) ? done : done8;
    end
    chk($sformatf("u%0d done within budget", u), 64'(seen), 64'(1));
    tick(1);
  endtask

  initial begin
    tick(2);
    chk("reset subkey", 64'(subkey), 64'h0);
    chk("reset round", 64'(subkey_round), 64'h0);
    chk("reset valid", 64'(subkey_valid), 64'h0);
    chk("reset subkey8", 64'(subkey8), 64'h0);
    rst_n = 1'b1;
    tick(1);

    // Encrypt with full throughput
    go(KEY_OK, 1'b0);
    chk("enc K1", 64'(subkey), 64'h1B02EFFC7072);
    chk("enc round1", 64'(subkey_round), 64'd1);
    chk("enc parity", 64'(parity_err), 64'h0);
    tick(1);
    chk("enc K2", 64'(subkey), 64'h79AED9DBC9E5);
    tick(14);
    chk("enc K16", 64'(subkey), 64'hCB3D8B0E17F5);
    chk("enc round16", 64'(subkey_round), 64'd16);
    tick(1);
    chk("enc done", 64'(done), 64'h1);
    chk("enc busy after", 64'(busy), 64'h0);
    tick(1);
    chk("enc done one cycle", 64'(done), 64'h0);

    // Decrypt order
    go(KEY_OK, 1'b1);
    chk("dec first", 64'(subkey), 64'hCB3D8B0E17F5);
    tick(15);
    chk("dec last", 64'(subkey), 64'h1B02EFFC7072);
    tick(1);
    chk("dec done", 64'(done), 64'h1);
    tick(1);

    // Even-parity byte flags the key but leaves subkeys intact
    go(KEY_BAD, 1'b0);
    chk("parity set", 64'(parity_err), 64'h1);
    chk("parity K1", 64'(subkey), 64'h1B02EFFC7072);
    wait_done(0, 40);
    chk("parity sticky", 64'(parity_err), 64'h1);
    go(KEY_OK, 1'b0);
    chk("parity clear", 64'(parity_err), 64'h0);
    wait_done(0, 40);

    // Start mid-run is ignored
    go(KEY_OK, 1'b0);
    tick(4);
    start = 1'b1; key_in = 64'h0123456789ABCDEF;
    tick(1);
    start = 1'b0;
    chk("ignored start round", 64'(subkey_round), 64'd6);
    wait_done(0, 40);

    // Start held across done: accepted only the cycle after the done pulse
    go(KEY_OK, 1'b0);
    tick(13);
    start = 1'b1; key_in = KEY_OK; decrypt = 1'b1;
    tick(3);
    chk("held done", 64'(done), 64'h1);
    tick(1);
    chk("held not in done", 64'(subkey_valid), 64'h0);
    tick(1);
    start = 1'b0;
    chk("held accept", 64'(subkey), 64'hCB3D8B0E17F5);
    wait_done(0, 40);

    // Reset in the middle of a run
    go(KEY_OK, 1'b0);
    tick(7);
    rst_n = 1'b0;
    #1;
    chk("midreset valid", 64'(subkey_valid), 64'h0);
    chk("midreset busy", 64'(busy), 64'h0);
    chk("midreset subkey", 64'(subkey), 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    go(KEY_OK, 1'b0);
    chk("restart K1", 64'(subkey), 64'h1B02EFFC7072);
    wait_done(0, 40);

    // Random keys, random direction, random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      go({$urandom, $urandom}, 1'($urandom_range(1)));
      wait_done(0, 400);
    end

    // Reduced-round instance
    rnd_ready = 1'b0;
    tick(2);
    go8(KEY_OK);
    chk("r8 K1", 64'(subkey8), 64'h1B02EFFC7072);
    tick(1);
    chk("r8 K2", 64'(subkey8), 64'h79AED9DBC9E5);
    tick(6);
    chk("r8 round8", 64'(subkey_round8), 64'd8);
    chk("r8 K8 standard", 64'(subkey8), 64'(ref_subkey(KEY_OK, 8, 16'h7EFC)));
    tick(1);
    chk("r8 done", 64'(done8), 64'h1);
    tick(1);
    rnd_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      go8({$urandom, $urandom});
      wait_done(1, 200);
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
